// File: rtl/lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_pkg
// Description : Shared defaults, checksum width and loader state encoding for
//               the reloadable lookup-table loader.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_pkg;

    localparam int DATAWIDTH_DEF = 15;
    localparam int ADDRWIDTH_DEF = 6;
    localparam int CSUM_W        = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lut_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : lut_loader_if
// Description : Valid/ready write stream carrying table words to the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface lut_loader_if #(
    parameter int DATAWIDTH = lut_pkg::DATAWIDTH_DEF
);
    logic                 wr_valid;
    logic [DATAWIDTH-1:0] wr_data;
    logic                 wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/lut_store.sv
`default_nettype none
// ============================================================================
// Module      : lut_store
// Description : Table storage with per-entry valid bitmap. Synchronous write,
//               combinational read returning 0 for entries not yet written,
//               single-cycle clear of every valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_store
    import lut_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 clear,
    input  wire logic                 we,
    input  wire logic [ADDRWIDTH-1:0] waddr,
    input  wire logic [DATAWIDTH-1:0] wdata,
    input  wire logic [ADDRWIDTH-1:0] raddr,
    output logic      [DATAWIDTH-1:0] rdata
);

    localparam int TBLSZ = 1 << ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem [TBLSZ];
    logic [TBLSZ-1:0]     vld;

    // Data array: no reset, the valid bitmap masks stale contents
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Valid bitmap: clear wins over a write so a restart never keeps an entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (clear) begin
            vld <= '0;
        end else if (we) begin
            vld[waddr] <= 1'b1;
        end
    end

    // Read port mirrors the ROM: unloaded entries read as zero
    assign rdata = vld[raddr] ? mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : lut_loader
// Description : Loads a stream of table words into sequential addresses
//               0..TBLSZ-1 and exposes a combinational ROM-style read port.
//               Optional running checksum of accepted words is enabled with
//               the macro LUT_LOADER_CHECKSUM_EN (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module lut_loader
    import lut_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 start,
    lut_loader_if.slave               wr,
    input  wire logic [ADDRWIDTH-1:0] address,
    output logic      [DATAWIDTH-1:0] data,
    output logic                      busy,
    output logic                      done,
    output logic      [CSUM_W-1:0]    checksum
);

    localparam int TBLSZ = 1 << ADDRWIDTH;

    state_t                 state;
    state_t                 state_next;
    logic [ADDRWIDTH-1:0]   ptr;
    logic                   ready;
    logic                   accept;
    logic                   last_word;

    // start has priority: a handshake coinciding with it is dropped
    assign accept      = (state == LOAD) && wr.wr_valid && !start;
    assign last_word   = (ptr == ADDRWIDTH'(TBLSZ - 1));
    assign wr.wr_ready = ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs decoded from the current state
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                ready = 1'b1;
                busy  = 1'b1;
                if (!start && accept && last_word) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write pointer: restarts on start, wraps naturally after the last entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (start) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr + 1'b1;
        end
    end

    lut_store #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .we    (accept),
        .waddr (ptr),
        .wdata (wr.wr_data),
        .raddr (address),
        .rdata (data)
    );

`ifdef LUT_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;

    // Running modulo-2^16 sum of every accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + CSUM_W'(wr.wr_data);
        end
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_loader
// Description : Self-checking bench for lut_loader: constant vector table,
//               directed multi-cycle sequences and randomized traffic checked
//               against a table/queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lut_loader;
    import lut_pkg::*;

    localparam int DW = DATAWIDTH_DEF;
    localparam int AW = ADDRWIDTH_DEF;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic [15:0]   checksum;

    int checks = 0;
    int errors = 0;

    lut_loader_if #(.DATAWIDTH(DW)) bus ();

    always #5 clk = ~clk;

    lut_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .wr       (bus),
        .address  (address),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    // Reference model: table contents, which entries are loaded, how many
    // words of the current load have arrived and their running sum.
    logic [DW-1:0] m_mem [N];
    bit            m_vld [N];
    int            m_count;     // words accepted in the current load
    bit            m_loading;
    bit            m_full;
    int            m_sum;

    logic [DW-1:0] rom [N];

    typedef struct {
        bit            st;
        bit            vl;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        bit            rdy;
        bit            bsy;
        bit            dn;
        logic [DW-1:0] q;
    } vec_t;
    vec_t vt [7];

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        return m_vld[a] ? m_mem[a] : '0;
    endfunction

    function automatic logic [15:0] exp_csum();
`ifdef LUT_LOADER_CHECKSUM_EN
        return m_sum[15:0];
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        m_count = 0; m_loading = 1'b0; m_full = 1'b0; m_sum = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One rising edge; model absorbs the same inputs the DUT sees
    task automatic step();
        @(posedge clk);
        if (start) begin
            for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
            m_count = 0; m_sum = 0; m_loading = 1'b1; m_full = 1'b0;
        end else if (m_loading && bus.wr_valid) begin
            m_mem[m_count] = bus.wr_data;
            m_vld[m_count] = 1'b1;
            m_sum = (m_sum + int'(bus.wr_data)) % 65536;
            m_count++;
            if (m_count == N) begin
                m_loading = 1'b0; m_full = 1'b1; m_count = 0;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ready"}, 32'(bus.wr_ready), 32'(m_loading));
        check({tag, "_busy"},  32'(busy),         32'(m_loading));
        check({tag, "_done"},  32'(done),         32'(m_full));
        check({tag, "_csum"},  32'(checksum),     32'(exp_csum()));
        check({tag, "_data"},  32'(data),         32'(exp_data(address)));
    endtask

    task automatic probe(input string name, input int a, input logic [DW-1:0] exp);
        address = AW'(a);
        #1;
        check(name, 32'(data), 32'(exp));
    endtask

    task automatic pulse_start();
        start = 1'b1; bus.wr_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    task automatic write_word(input logic [DW-1:0] d, input bit gaps);
        if (gaps) begin
            int g = int'($urandom_range(0, 3));
            bus.wr_valid = 1'b0;
            for (int i = 0; i < g; i++) step();
        end
        bus.wr_valid = 1'b1; bus.wr_data = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        model_reset();

        for (int i = 0; i < N; i++) rom[i] = DW'((i * 32'h1F3 + 32'h155) & 32'h7FFF);
        rom[0] = 15'h7E06; rom[26] = 15'h4004; rom[63] = 15'h2041;

        //          st  vl  data      addr  rdy bsy dn  data-out
        vt[0] = '{1'b0, 1'b1, 15'h1234, 6'd0, 1'b0, 1'b0, 1'b0, 15'h0000};
        vt[1] = '{1'b1, 1'b1, 15'h1234, 6'd0, 1'b1, 1'b1, 1'b0, 15'h0000};
        vt[2] = '{1'b0, 1'b1, 15'h0AAA, 6'd0, 1'b1, 1'b1, 1'b0, 15'h0AAA};
        vt[3] = '{1'b0, 1'b0, 15'h7777, 6'd1, 1'b1, 1'b1, 1'b0, 15'h0000};
        vt[4] = '{1'b0, 1'b1, 15'h0BBB, 6'd1, 1'b1, 1'b1, 1'b0, 15'h0BBB};
        vt[5] = '{1'b1, 1'b1, 15'h0CCC, 6'd0, 1'b1, 1'b1, 1'b0, 15'h0000};
        vt[6] = '{1'b0, 1'b1, 15'h5555, 6'd0, 1'b1, 1'b1, 1'b0, 15'h5555};

        // Reset state
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        probe("rst_data0", 0, 15'h0);
        probe("rst_data31", 31, 15'h0);
        probe("rst_data63", 63, 15'h0);
        check("rst_ready", 32'(bus.wr_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_csum", 32'(checksum), 0);

        // Vector table from reset
        for (int i = 0; i < 7; i++) begin
            start = vt[i].st; bus.wr_valid = vt[i].vl;
            bus.wr_data = vt[i].d; address = vt[i].a;
            step();
            check($sformatf("vec%0d_ready", i), 32'(bus.wr_ready), 32'(vt[i].rdy));
            check($sformatf("vec%0d_busy", i),  32'(busy),         32'(vt[i].bsy));
            check($sformatf("vec%0d_done", i),  32'(done),         32'(vt[i].dn));
            check($sformatf("vec%0d_data", i),  32'(data),         32'(vt[i].q));
        end
        start = 1'b0; bus.wr_valid = 1'b0;

        // Full ROM load with wr_valid held high
        pulse_start();
        bus.wr_valid = 1'b1;
        cyc = 0;
        for (int i = 0; i < N; i++) begin
            bus.wr_data = rom[i];
            step();
            cyc++;
            if (i == N - 2) check("full_done_early", 32'(done), 0);
        end
        bus.wr_valid = 1'b0;
        check("full_done", 32'(done), 1);
        check("full_busy", 32'(busy), 0);
        check("full_cycles", 32'(cyc), 32'(N));
        probe("full_data0", 0, 15'h7E06);
        probe("full_data26", 26, 15'h4004);
        probe("full_data63", 63, 15'h2041);
        check_model("full");

        // Writes attempted in DONE are ignored
        bus.wr_valid = 1'b1; bus.wr_data = 15'h7FFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("donewr_ready", 32'(bus.wr_ready), 0);
            check("donewr_csum", 32'(checksum), 32'(exp_csum()));
        end
        bus.wr_valid = 1'b0;
        probe("donewr_data0", 0, 15'h7E06);
        probe("donewr_data63", 63, 15'h2041);

        // Read of the entry being written returns the prior value that cycle
        pulse_start();
        write_word(15'h0101, 1'b0);
        write_word(15'h0202, 1'b0);
        write_word(15'h0303, 1'b0);
        address = 6'd3; bus.wr_valid = 1'b1; bus.wr_data = 15'h5555;
        #1;
        check("rdw_same_cycle", 32'(data), 0);
        step();
        bus.wr_valid = 1'b0;
        check("rdw_next_cycle", 32'(data), 32'h5555);

        // Restart mid-load leaves no stale entries
        pulse_start();
        for (int i = 1; i <= 10; i++) write_word(DW'(i), 1'b1);
        probe("pre_restart_data5", 5, 15'h0006);
        pulse_start();
        probe("restart_data5", 5, 15'h0);
        check("restart_csum", 32'(checksum), 0);
        bus.wr_valid = 1'b1; bus.wr_data = 15'h1111;
        for (int i = 0; i < N; i++) step();
        bus.wr_valid = 1'b0;
        probe("restart_final5", 5, 15'h1111);
`ifdef LUT_LOADER_CHECKSUM_EN
        check("restart_final_csum", 32'(checksum), 32'h4440);
`else
        check("restart_final_csum", 32'(checksum), 32'h0000);
`endif
        check("restart_final_done", 32'(done), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            start        = ($urandom_range(0, 149) == 0);
            bus.wr_valid = ($urandom_range(0, 2) != 0);
            bus.wr_data  = DW'($urandom);
            address      = AW'($urandom);
            step();
            check_model($sformatf("rnd%0d", i));
        end
        start = 1'b0; bus.wr_valid = 1'b0;

        // Asynchronous reset in the middle of a load at ptr=40
        pulse_start();
        for (int i = 0; i < 40; i++) write_word(DW'(i + 100), 1'b0);
        probe("mid_data0", 0, 15'd100);
        rst_n = 1'b0;
        #1;
        check("arst_done", 32'(done), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(bus.wr_ready), 0);
        check("arst_data0", 32'(data), 0);
        check("arst_csum", 32'(checksum), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        probe("arst_after_data39", 39, 15'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time guard
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Writer-side counterpart to the team's 64-entry lookup-table ROM read path.
- Accepts a stream of table words over a valid/ready handshake and writes them into internal storage at sequential addresses 0..TBLSZ-1.
- Provides the same combinational address-to-data read port as the ROM, so downstream logic can use a reloadable table instead of a fixed one.
- Sits between the configuration/boot stream source and the table consumer.

Parameters:
- DATAWIDTH, 15, width of one table word.
- ADDRWIDTH, 6, table address width.
- TBLSZ, 1 << ADDRWIDTH, number of entries; always a power of two.

Ports:
- clk  input  1  single clock for the block.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins or restarts a table load.
- wr_valid  input  1  wr_data is valid.
- wr_data  input  DATAWIDTH  table word for the current write pointer.
- wr_ready  output  1  loader accepts a word this cycle.
- address  input  ADDRWIDTH  read address.
- data  output  DATAWIDTH  read data, combinational from address.
- busy  output  1  high while a load is in progress.
- done  output  1  high once all TBLSZ entries are written; held until the next start or reset.
- checksum  output  16  running sum of loaded words (see Optional Feature).

Behaviour:
- Storage: mem[TBLSZ] of DATAWIDTH bits, plus a valid bitmap vld[TBLSZ].
- Read path: data = vld[address] ? mem[address] : 0, purely combinational. This matches the ROM default of 0 for unloaded entries.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, ptr=0, vld all 0.
  - wr_ready=0, busy=0, done=0, checksum=0.
  - data therefore reads 0 for every address.
  - mem contents need no reset.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: wr_ready=0. On start -> LOAD; ptr=0, vld cleared, checksum=0.
  - LOAD: wr_ready=1, busy=1. A handshake (wr_valid & wr_ready) at a rising edge writes mem[ptr]=wr_data, sets vld[ptr]=1 and increments ptr.
    - Handshake with ptr==TBLSZ-1 -> DONE; done=1, busy=0, ptr wraps to 0.
    - wr_valid=0: hold; ptr unchanged.
  - DONE: wr_ready=0. wr_valid is ignored; no write occurs and no error is raised. On start -> LOAD, with the same clearing as from IDLE.
- start during LOAD aborts the load:
  - ptr=0, vld cleared, checksum=0; state stays LOAD.
  - A handshake in the same cycle as start is discarded; start has priority.
- Write latency: a written word appears on data from the cycle after the handshake edge.
  - Reading the address being written in that same cycle returns the prior value: 0 if not yet valid, otherwise the old mem contents.
- Reset mid-load: everything returns to reset values immediately; a partial table is not retained.
- done and busy are never both 1.
- ptr is ADDRWIDTH bits wide; the wrap from TBLSZ-1 to 0 is natural overflow.

Optional Feature:
- Macro: LUT_LOADER_CHECKSUM_EN.
- Defined:
  - checksum = sum modulo 2^16 of every accepted wr_data, each zero-extended to 16 bits.
  - Updates on each handshake; cleared on reset and on start.
  - Holds its value in DONE.
- Not defined: checksum is tied to 0 and no adder is built.

Decomposition:
- Shared package lut_pkg holds:
  - DATAWIDTH/ADDRWIDTH defaults;
  - the state enum (IDLE, LOAD, DONE);
  - the checksum width constant (16).
- One natural sub-module, lut_store: mem plus vld bitmap, with a synchronous write port, a combinational read port and a clear-all input.
- The FSM, pointer and checksum stay in lut_loader.

Test Plan:
- Reset, no start -> data==0 for addresses 0, 31 and 63; wr_ready=0; busy=0; done=0.
- start, then stream the 64 ROM words (0x7E06 .. 0x2041) with wr_valid held high -> done rises on the edge after the 64th handshake, 64 cycles after LOAD entry. data@0=0x7E06, data@26=0x4004, data@63=0x2041. With LUT_LOADER_CHECKSUM_EN defined, checksum equals the mod-2^16 sum of the 64 words.
- Load 10 words 0x0001..0x000A with random wr_valid gaps, then pulse start, then load 64 words of 0x1111 -> no stale values:
  - after the restart and before rewriting, data@5 reads 0;
  - final data@5=0x1111; checksum=0x4440.
- Read address 3 while word 0x5555 is written to ptr 3 -> data=0 in the handshake cycle, 0x5555 the following cycle.
- In DONE, assert wr_valid with 0x7FFF for 5 cycles -> no mem change; wr_ready=0; checksum unchanged.
- Assert rst_n=0 mid-load at ptr=40 -> done=0, busy=0, data@0==0 immediately, without waiting for a clock edge.
